// File: rtl/imem_debug_arbiter.sv
// Arbitrates the instruction memory debug port between loader (0) and debug reader (1).
// Latency: grant is combinational; response is registered, one cycle after accept.
// Backpressure: req_ready holds off the loser; responses cannot be stalled.
module imem_debug_arbiter #(
    parameter int ADDR_LIMIT_BITS = 14,
    parameter int MAX_LOCK        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_we,
    input  logic [1:0]  req_lock,
    input  logic [29:0] req_addr0,
    input  logic [29:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    output logic [1:0]  resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        write_en,
    output logic [29:0] debug_addr,
    output logic [31:0] debug_input,
    input  logic [31:0] debug_data
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic             last_q;
    logic             lock_q, lock_nxt;
    logic             owner_q, owner_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             forced;
    logic             gnt_any;
    logic             gnt_id;
    logic             in_range;
    logic [1:0]       resp_valid_q;
    logic             resp_err_q;

    assign forced = lock_q && (cnt_q >= CNT_W'(MAX_LOCK));

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = 1'b0;
        if (rst_n) begin
            case (req_valid)
                2'b01: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b0;
                end
                2'b10: begin
                    gnt_any = 1'b1;
                    gnt_id  = 1'b1;
                end
                2'b11: begin
                    gnt_any = 1'b1;
                    if (lock_q)
                        gnt_id = forced ? ~owner_q : owner_q;
                    else
                        gnt_id = ~last_q;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready   = 2'b00;
        debug_addr  = gnt_id ? req_addr1 : req_addr0;
        debug_input = gnt_id ? req_wdata1 : req_wdata0;
        in_range    = (debug_addr[29:ADDR_LIMIT_BITS-2] == '0);
        write_en    = gnt_any && req_we[gnt_id] && in_range;
        if (gnt_any)
            req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    // A fresh lock request from the other side takes over even in the forced-out cycle.
    always_comb begin
        lock_nxt  = lock_q;
        owner_nxt = owner_q;
        cnt_nxt   = cnt_q;
        if (lock_q && !req_valid[owner_q]) begin
            lock_nxt = 1'b0;
            cnt_nxt  = '0;
        end
        if (gnt_any) begin
            if (req_lock[gnt_id]) begin
                if (lock_q && (owner_q == gnt_id)) begin
                    if (cnt_q < CNT_W'(MAX_LOCK))
                        cnt_nxt = cnt_q + CNT_W'(1);
                end else begin
                    lock_nxt  = 1'b1;
                    owner_nxt = gnt_id;
                    cnt_nxt   = CNT_W'(1);
                end
            end else begin
                lock_nxt = 1'b0;
                cnt_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= 1'b1;
            lock_q       <= 1'b0;
            owner_q      <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 2'b00;
            resp_err_q   <= 1'b0;
        end else begin
            lock_q       <= lock_nxt;
            owner_q      <= owner_nxt;
            cnt_q        <= cnt_nxt;
            if (gnt_any)
                last_q <= gnt_id;
            resp_valid_q <= req_ready;
            resp_err_q   <= gnt_any && !in_range;
        end
    end

    // Memory read data lands in the response cycle, so it is muxed, not re-registered.
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = ((|resp_valid_q) && !resp_err_q) ? debug_data : 32'h0;

endmodule
